// File: rtl/vector_mul_scheduler.sv
// Round-robin issue scheduler and tagged result buffer for the shared
// vector multiplier, with pipeline drain on precision changes.
module vector_mul_scheduler #(
  parameter int MUL_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [1:0]       req0_precision,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [1:0]       req1_precision,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [31:0]      mul_operand_a,
  output logic [31:0]      mul_operand_b,
  output logic [1:0]       mul_precision,
  input  logic [63:0]      mul_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_data,
  output logic             rsp_src,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + MUL_LATENCY + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]             r_state;
  logic [1:0]             w_next;
  logic                   r_last;
  logic [31:0]            r_a;
  logic [31:0]            r_b;
  logic [1:0]             r_prec;

  logic [MUL_LATENCY-1:0] r_sv;
  logic [MUL_LATENCY-1:0] r_ss;
  logic [TAG_W-1:0]       r_st [MUL_LATENCY];

  logic [63:0]            r_md [FIFO_DEPTH];
  logic                   r_ms [FIFO_DEPTH];
  logic [TAG_W-1:0]       r_mt [FIFO_DEPTH];
  logic [AW-1:0]          r_wp;
  logic [AW-1:0]          r_rp;
  logic [CW-1:0]          r_cnt;

  logic                   w_win;
  logic                   w_wv;
  logic [31:0]            w_wa;
  logic [31:0]            w_wb;
  logic [1:0]             w_wprec;
  logic [TAG_W-1:0]       w_wtag;
  logic [CW-1:0]          w_infl;
  logic                   w_credit;
  logic                   w_issue;
  logic                   w_push;
  logic                   w_pop;

  // both valid: the requester that was not served last wins
  assign w_win   = (req0_valid & req1_valid) ? ~r_last : req1_valid;
  assign w_wv    = req0_valid | req1_valid;
  assign w_wa    = w_win ? req1_a : req0_a;
  assign w_wb    = w_win ? req1_b : req0_b;
  assign w_wprec = w_win ? req1_precision : req0_precision;
  assign w_wtag  = w_win ? req1_tag : req0_tag;

  always_comb begin
    w_infl = '0;
    for (int i = 0; i < MUL_LATENCY; i++) begin
      w_infl = w_infl + CW'(r_sv[i]);
    end
  end

  assign w_credit = (w_infl + r_cnt) < CW'(FIFO_DEPTH);

  always_comb begin
    w_issue = 1'b0;
    w_next  = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_wv && w_credit) begin
          w_issue = 1'b1;
          w_next  = S_RUN;
        end
      end
      S_RUN: begin
        if (w_wv) begin
          if (w_wprec != r_prec) begin
            w_next = S_DRAIN;
          end else if (w_credit) begin
            w_issue = 1'b1;
          end
        end else if (w_infl == '0) begin
          w_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (w_infl == '0) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign req0_ready = rst & w_issue & ~w_win;
  assign req1_ready = rst & w_issue & w_win;

  assign w_push    = r_sv[MUL_LATENCY-1];
  assign rsp_valid = (r_cnt != '0);
  assign w_pop     = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_a     <= '0;
      r_b     <= '0;
      r_prec  <= '0;
      r_sv    <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_last <= w_win;
        r_a    <= w_wa;
        r_b    <= w_wb;
        r_prec <= w_wprec;
      end
      r_sv[0] <= w_issue;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        r_sv[i] <= r_sv[i-1];
      end
      if (w_push) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // payload storage needs no reset: it is qualified by r_sv / r_cnt
  always_ff @(posedge clk) begin
    r_ss[0] <= w_win;
    r_st[0] <= w_wtag;
    for (int i = 1; i < MUL_LATENCY; i++) begin
      r_ss[i] <= r_ss[i-1];
      r_st[i] <= r_st[i-1];
    end
    if (w_push) begin
      r_md[r_wp] <= mul_result;
      r_ms[r_wp] <= r_ss[MUL_LATENCY-1];
      r_mt[r_wp] <= r_st[MUL_LATENCY-1];
    end
  end

  assign mul_operand_a = r_a;
  assign mul_operand_b = r_b;
  assign mul_precision = r_prec;

  assign rsp_data = rsp_valid ? r_md[r_rp] : '0;
  assign rsp_src  = rsp_valid ? r_ms[r_rp] : 1'b0;
  assign rsp_tag  = rsp_valid ? r_mt[r_rp] : '0;

  assign busy = (r_state != S_IDLE) | (w_infl != '0) | rsp_valid;

endmodule

// File: doc/vector_mul_scheduler.md
# vector_mul_scheduler

Issue scheduler and result buffer for the shared 32-bit vector multiplier. It arbitrates between two requesters with round-robin fairness and drives the multiplier's operand and precision inputs. It tracks in-flight operations through the multiplier's fixed pipeline latency and returns tagged results through a valid/ready response port. It also drains the pipeline before any precision change, because the multiplier's lane muxing depends on `precision`.

## Interface
- `MUL_LATENCY`, 2: cycles from a `mul_operand_*`/`mul_precision` update to the matching `mul_result`; ≥1.
- `FIFO_DEPTH`, 4: response FIFO entries and maximum outstanding operations (in-flight plus buffered); power of two, ≥2.
- `TAG_W`, 4: requester tag width.

- `clk` input 1: the block's single clock.
- `rst` input 1: asynchronous, active-low reset.
- `req0_valid`/`req1_valid` input 1: request pending.
- `req0_ready`/`req1_ready` output 1: grant; acceptance happens on `valid & ready` at the clock edge.
- `req0_a`/`req1_a`, `req0_b`/`req1_b` input 32: operands.
- `req0_precision`/`req1_precision` input 2: multiplier precision code.
- `req0_tag`/`req1_tag` input TAG_W: opaque tag, returned with the result.
- `mul_operand_a`, `mul_operand_b` output 32: registered operands to the multiplier.
- `mul_precision` output 2: registered mode to the multiplier.
- `mul_result` input 64: multiplier output.
- `rsp_valid` output 1: FIFO head valid.
- `rsp_ready` input 1: consumer accepts the head.
- `rsp_data` output 64, `rsp_src` output 1, `rsp_tag` output TAG_W: head result, originating requester, and tag.
- `busy` output 1: state ≠ IDLE, or any operation in flight, or FIFO non-empty.

## Operation
- Round-robin arbitration:
  - Pointer `last` holds the most recently accepted requester.
  - When both requesters are valid, the winner is the requester ≠ `last`.
  - With one valid requester, that requester wins.
  - `last` updates only on acceptance.
- Credit rule: an issue requires (in-flight count + FIFO occupancy) < FIFO_DEPTH. This makes FIFO overflow impossible.
- FSM:
  - IDLE (mode unlocked):
    - If the winner is valid and credit is available: assert its ready, load its precision into `mul_precision`, load its operands, and go to RUN.
  - RUN (mode locked):
    - Winner precision equals `mul_precision` and credit is available: assert its ready and issue. Sustained rate is one issue per cycle.
    - Winner precision differs: no ready is asserted, and the FSM goes to DRAIN. The other requester is not granted in its place, which keeps arbitration order.
    - No valid request and nothing in flight: go to IDLE.
  - DRAIN:
    - All readies stay low.
    - When the in-flight count reaches 0, go to IDLE. IDLE then issues the pending request with its new precision.
- Precision codes are compared exactly, so 2'b10 and 2'b11 are different modes.
- In-flight tracking: a MUL_LATENCY-deep shift register of {valid, src, tag}, advanced every cycle.
  - When the tail is valid, `{mul_result, src, tag}` is pushed into the FIFO at that edge.
- The FIFO supports simultaneous push and pop in the same cycle, including when it is full.
- `rsp_*` outputs come directly from the FIFO head. They are stable while `rsp_valid & !rsp_ready`.
- `reqN_ready` is combinational from the valid inputs and state. Requesters must not make `valid` depend on `ready`.
- `mul_operand_*` hold their last issued values when no issue occurs.
- Arithmetic is not performed here. `rsp_data` is exactly the 64-bit `mul_result` sampled for that operation.

## Timing
- Reset (asynchronous, while `rst`=0):
  - FSM goes to IDLE, `last`=1 (so req0 wins first), shift register and FIFO are cleared.
  - All outputs read 0: readies, `rsp_*`, `busy`, `mul_operand_*`, `mul_precision`.
- Reset mid-operation discards all in-flight and buffered results. No stale response appears after release.
- Acceptance edge E loads the operand registers. The result is pushed into the FIFO at edge E+MUL_LATENCY.
  - If the FIFO was empty, `rsp_valid` rises in the cycle after that edge.
  - Acceptance-to-response latency is therefore MUL_LATENCY cycles.
- A precision switch costs MUL_LATENCY+1 idle issue cycles: the DRAIN cycles, then one IDLE issue.
- Back-pressure: with `rsp_ready`=0, exactly FIFO_DEPTH requests are accepted, and then readies stay low. Each pop frees one credit at that edge.

## Test plan
- Single request: req0 a=3, b=5, precision=2'b10, tag=1. Expect `rsp_data`=15, `rsp_src`=0, `rsp_tag`=1, with `rsp_valid` asserted MUL_LATENCY cycles after acceptance. Expect `busy` to return to 0 after the pop.
- Fairness: both requesters valid continuously with the same precision and `rsp_ready`=1. Expect grants to alternate 0,1,0,1 at one per cycle. Expect responses in issue order with the correct src and tag.
- Precision switch: req0 issues three 2'b10 operations, then presents 2'b00. Expect ready low for the DRAIN period. Expect `mul_precision` to change only after the third result has been pushed. Expect the 2'b00 request to issue from IDLE.
- Back-pressure (FIFO_DEPTH=4, `rsp_ready`=0): expect exactly 4 acceptances, then ready low. A single-cycle `rsp_ready` pulse allows exactly one more acceptance. No entry may be lost or duplicated.
- Full-scale operands: a=b=32'hFFFF_FFFF, precision 2'b10. Expect `rsp_data`=64'hFFFF_FFFE_0000_0001 to be passed through unchanged.
- Reset mid-flight: assert `rst`=0 with 2 operations in flight and 1 buffered. Expect `rsp_valid` and `busy` to read 0 immediately. After release with no requests, no response appears within 2×MUL_LATENCY cycles.
